// File: rtl/serial_adder_pkg.sv
// Shared state encodings and sizing helpers for the serial_adder block.
package serial_adder_pkg;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = S_IDLE,
        ST_RUN  = S_RUN,
        ST_DONE = S_DONE
    } state_t;

    // Digit counter width: clog2 of the digit count, never narrower than one bit.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = (digit > 0) ? width / digit : 1;
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; ovf exists only with SERIAL_ADDER_OVF_EN.
interface serial_adder_if #(parameter int WIDTH = 8);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum,
`ifdef SERIAL_ADDER_OVF_EN
        input  ovf,
`endif
        input  cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum,
`ifdef SERIAL_ADDER_OVF_EN
        output ovf,
`endif
        output cout
    );

endinterface

// File: rtl/full_adder_cell.sv
// Single-bit full adder; chained DIGIT times to form the per-cycle ripple stage.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: DIGIT bits per clock, LSB first, valid/ready on both sides.
// Optional signed-overflow flag built when SERIAL_ADDER_OVF_EN is defined.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);

    localparam int N  = (DIGIT > 0) ? WIDTH / DIGIT : 1;
    localparam int CW = cnt_width(WIDTH, DIGIT);

    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder: illegal WIDTH/DIGIT combination");
    end

    state_t           state, state_nx;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r;
    logic             c, cout_r;
    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] dsum;
    logic             last, accept, release_res;

    // Ripple chain seeded by the carry left over from the previous digit.
    assign chain[0] = c;
    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder_cell u_fa (
            .a  (a_sh[i]),
            .b  (b_sh[i]),
            .ci (chain[i]),
            .s  (dsum[i]),
            .co (chain[i+1])
        );
    end

    assign last        = (cnt == CW'(N - 1));
    assign accept      = bus.in_valid && (state == ST_IDLE);
    assign release_res = bus.out_ready && (state == ST_DONE);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (accept)      state_nx = ST_RUN;
            ST_RUN:  if (last)        state_nx = ST_DONE;
            ST_DONE: if (release_res) state_nx = ST_IDLE;
            default:                  state_nx = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers sample together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    // Datapath registers are reset too: reset must clear sum/cout visibly, not just the FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            c      <= 1'b0;
            cout_r <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    a_sh <= bus.a;
                    b_sh <= bus.b;
                    c    <= bus.cin;
                    cnt  <= '0;
                end
                ST_RUN: begin
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    sum_r <= (sum_r >> DIGIT) | (WIDTH'(dsum) << (WIDTH - DIGIT));
                    c     <= chain[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) cout_r <= chain[DIGIT];
                end
                default: ;
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_r;

    // On the final digit chain[DIGIT-1] is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      ovf_r <= 1'b0;
        else if (state == ST_RUN && last) ovf_r <= chain[DIGIT-1] ^ chain[DIGIT];
    end

    assign bus.ovf = ovf_r;
`endif

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.sum       = sum_r;
    assign bus.cout      = cout_r;

endmodule
